// File: rtl/ram_port_arbiter.sv
// Byte-serial arbiter sharing one RAM port between instruction fetch and load/store.
// Splits 1/2/4-byte little-endian accesses into per-byte RAM cycles and returns a done pulse.
module ram_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  input  logic                     if_flush,
  output logic                     if_done,
  output logic [8*MAX_BYTES-1:0]   if_data,
  input  logic                     mem_req,
  input  logic                     mem_we,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [1:0]               mem_size,
  input  logic [8*MAX_BYTES-1:0]   mem_wdata,
  output logic                     mem_done,
  output logic [8*MAX_BYTES-1:0]   mem_rdata,
  input  logic [7:0]               ram_din,
  output logic [7:0]               ram_dout,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_wr,
  output logic                     busy
);

  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int CNT_W  = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [CNT_W-1:0]    n_bytes, n_bytes_nx;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_nx;
  logic [DATA_W-1:0]   cur_wdata, cur_wdata_nx;
  logic                cur_mem, cur_mem_nx;
  logic                last_mem, last_mem_nx;
  logic [DATA_W-1:0]   rbuf, rbuf_nx;
  logic                if_done_nx, mem_done_nx, ram_wr_nx, busy_nx;
  logic [DATA_W-1:0]   if_data_nx, mem_rdata_nx;
  logic [7:0]          ram_dout_nx;
  logic [ADDR_W-1:0]   ram_addr_nx;

  logic                mem_cand, if_cand, grant_mem, grant_if;
  logic                flush_abort, last_byte;
  logic [CNT_W-1:0]    mem_n;

  // A requester whose done is still high is finishing this cycle and must not be re-granted.
  assign mem_cand    = mem_req & ~mem_done;
  assign if_cand     = if_req & ~if_done & ~if_flush;
  assign grant_mem   = mem_cand & (~if_cand | ~last_mem);
  assign grant_if    = if_cand & ~grant_mem;
  assign flush_abort = ~cur_mem & if_flush;
  assign last_byte   = (cnt == n_bytes);

  always_comb begin
    case (mem_size)
      2'b00:   mem_n = CNT_W'(1);
      2'b01:   mem_n = CNT_W'(2);
      default: mem_n = CNT_W'(MAX_BYTES);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      n_bytes   <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_mem   <= 1'b0;
      last_mem  <= 1'b0;
      rbuf      <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      ram_dout  <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      n_bytes   <= n_bytes_nx;
      cur_addr  <= cur_addr_nx;
      cur_wdata <= cur_wdata_nx;
      cur_mem   <= cur_mem_nx;
      last_mem  <= last_mem_nx;
      rbuf      <= rbuf_nx;
      if_done   <= if_done_nx;
      if_data   <= if_data_nx;
      mem_done  <= mem_done_nx;
      mem_rdata <= mem_rdata_nx;
      ram_dout  <= ram_dout_nx;
      ram_addr  <= ram_addr_nx;
      ram_wr    <= ram_wr_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_mem || grant_if) state_nx = (grant_mem && mem_we) ? WRITE : READ;
      READ:    if (flush_abort || last_byte) state_nx = IDLE;
      WRITE:   if (last_byte) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx       = cnt;
    n_bytes_nx   = n_bytes;
    cur_addr_nx  = cur_addr;
    cur_wdata_nx = cur_wdata;
    cur_mem_nx   = cur_mem;
    last_mem_nx  = last_mem;
    rbuf_nx      = rbuf;
    if_done_nx   = 1'b0;
    mem_done_nx  = 1'b0;
    if_data_nx   = if_data;
    mem_rdata_nx = mem_rdata;
    ram_dout_nx  = ram_dout;
    ram_addr_nx  = ram_addr;
    ram_wr_nx    = ram_wr;
    busy_nx      = (state_nx != IDLE);
    case (state)
      IDLE: begin
        if (grant_mem || grant_if) begin
          cur_mem_nx   = grant_mem;
          last_mem_nx  = grant_mem;
          cur_addr_nx  = grant_mem ? mem_addr : if_addr;
          n_bytes_nx   = grant_mem ? mem_n : CNT_W'(MAX_BYTES);
          cur_wdata_nx = mem_wdata;
          ram_addr_nx  = grant_mem ? mem_addr : if_addr;
          cnt_nx       = CNT_W'(1);
          rbuf_nx      = '0;
          ram_wr_nx    = grant_mem & mem_we;
          if (grant_mem && mem_we) ram_dout_nx = mem_wdata[7:0];
        end
      end
      READ: begin
        if (!flush_abort) begin
          for (int b = 0; b < MAX_BYTES; b++)
            if (cnt == CNT_W'(b + 1)) rbuf_nx[8*b +: 8] = ram_din;
          if (last_byte) begin
            if (cur_mem) begin
              mem_done_nx  = 1'b1;
              mem_rdata_nx = rbuf_nx;
            end else begin
              if_done_nx = 1'b1;
              if_data_nx = rbuf_nx;
            end
          end else begin
            ram_addr_nx = cur_addr + ADDR_W'(cnt);
            cnt_nx      = cnt + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (last_byte) begin
          ram_wr_nx   = 1'b0;
          mem_done_nx = 1'b1;
        end else begin
          ram_addr_nx = cur_addr + ADDR_W'(cnt);
          for (int b = 0; b < MAX_BYTES; b++)
            if (cnt == CNT_W'(b)) ram_dout_nx = cur_wdata[8*b +: 8];
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
